// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode field values (inst[6:2]), the canonical NOP
// and the decode scheduler state type.
package riscv_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } id_sched_state_e;

endpackage

// File: rtl/id_src_use.sv
// Source/destination register decode of one instruction, shared by the
// load-use hazard check and the forwarding unit.
module id_src_use
  import riscv_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_is_load,
  output logic [4:0]  o_rd
);

  logic [4:0] opc;
  logic       unused_bits;

  assign opc         = i_inst[6:2];
  assign o_rs1       = i_inst[19:15];
  assign o_rs2       = i_inst[24:20];
  assign o_rd        = i_inst[11:7];
  assign unused_bits = ^{i_inst[31:25], i_inst[14:12], i_inst[1:0]};

  always_comb begin
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_is_load  = 1'b0;
    case (opc)
      OP_OP, OP_STORE, OP_BRANCH: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OP_OPIMM, OP_JALR: o_uses_rs1 = 1'b1;
      OP_LOAD: begin
        o_uses_rs1 = 1'b1;
        o_is_load  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_issue_sched.sv
// Decode-stage scheduler: owns the IF/ID register, inserts one bubble on a
// load-use hazard and squashes wrong-path beats after an EX redirect.
//   state | meaning
//   RUN   | normal capture / issue
//   FLUSH | post-redirect window, fetch beats accepted and dropped
module id_issue_sched
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_if_valid,
  input  logic [31:0]      i_if_inst,
  input  logic [31:0]      i_if_pc,
  output logic             o_if_ready,
  output logic             o_id_valid,
  output logic [31:0]      o_id_inst,
  output logic [31:0]      o_id_pc,
  input  logic             i_id_ready,
  input  logic             i_ex_redirect,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);

  id_sched_state_e state_q, state_d;
  logic [2:0]       fl_cnt_q, fl_cnt_d;
  logic             ir_valid_q, ir_valid_d;
  logic [31:0]      ir_inst_q, ir_inst_d;
  logic [31:0]      ir_pc_q, ir_pc_d;
  logic             ld_pend_q, ld_pend_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       uses_rs1, uses_rs2, is_load;
  logic [4:0] rs1, rs2, rd;
  logic       hazard, id_valid, issue, if_ready, capture;

  id_src_use u_src_use (
    .i_inst     (ir_inst_q),
    .o_uses_rs1 (uses_rs1),
    .o_uses_rs2 (uses_rs2),
    .o_rs1      (rs1),
    .o_rs2      (rs2),
    .o_is_load  (is_load),
    .o_rd       (rd)
  );

  always_comb begin
    hazard   = ld_pend_q && ir_valid_q &&
               ((uses_rs1 && (rs1 == ld_rd_q)) || (uses_rs2 && (rs2 == ld_rd_q)));
    // Reset gating keeps the handshake quiet while the flops are being cleared.
    id_valid = ir_valid_q && (state_q == RUN) && !hazard && !i_ex_redirect && !i_reset;
    issue    = id_valid && i_id_ready;
    if_ready = i_reset || !ir_valid_q || issue || (state_q == FLUSH) || i_ex_redirect;
    capture  = i_if_valid && if_ready && (state_q == RUN) && !i_ex_redirect;

    state_d     = state_q;
    fl_cnt_d    = fl_cnt_q;
    ir_valid_d  = ir_valid_q;
    ir_inst_d   = ir_inst_q;
    ir_pc_d     = ir_pc_q;
    ld_pend_d   = ld_pend_q;
    ld_rd_d     = ld_rd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (i_ex_redirect) begin
      ir_valid_d  = 1'b0;
      ld_pend_d   = 1'b0;
      flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
      if (FLUSH_CYCLES > 1) begin
        state_d  = FLUSH;
        fl_cnt_d = FL_LOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (state_q == FLUSH) begin
        if (fl_cnt_q <= 3'd1) state_d = RUN;
        else                  fl_cnt_d = fl_cnt_q - 3'd1;
      end
      if (hazard && i_id_ready) begin
        ld_pend_d   = 1'b0;
        stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
      end else begin
        if (issue && is_load && (rd != 5'd0)) begin
          ld_pend_d = 1'b1;
          ld_rd_d   = rd;
        end else if (i_id_ready) begin
          ld_pend_d = 1'b0;
        end
        if (capture) begin
          ir_valid_d = 1'b1;
          ir_inst_d  = i_if_inst;
          ir_pc_d    = i_if_pc;
        end else if (issue) begin
          ir_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= RUN;
      fl_cnt_q    <= 3'd0;
      ir_valid_q  <= 1'b0;
      ir_inst_q   <= NOP_INST;
      ir_pc_q     <= 32'd0;
      ld_pend_q   <= 1'b0;
      ld_rd_q     <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fl_cnt_q    <= fl_cnt_d;
      ir_valid_q  <= ir_valid_d;
      ir_inst_q   <= ir_inst_d;
      ir_pc_q     <= ir_pc_d;
      ld_pend_q   <= ld_pend_d;
      ld_rd_q     <= ld_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_id_valid  = id_valid;
  assign o_if_ready  = if_ready;
  assign o_id_inst   = ir_inst_q;
  assign o_id_pc     = ir_pc_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_issue_sched.sv
// Bench for id_issue_sched: three instances (default, FLUSH_CYCLES=3, CNT_W=2)
// share stimulus; each is compared every cycle against a behavioural model.
module tb_id_issue_sched;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LW5   = 32'h0000_A283;  // lw  x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h0022_8333;  // add x6,x5,x2
  localparam logic [31:0] ADD7  = 32'h0020_83B3;  // add x7,x1,x2
  localparam logic [31:0] LW0   = 32'h0000_A003;  // lw  x0,0(x1)
  localparam logic [31:0] ADD60 = 32'h0020_0333;  // add x6,x0,x2
  localparam logic [31:0] LUI5  = 32'h0000_12B7;  // lui x5,1

  logic        clk = 1'b0;
  logic        rst, ifv, idr, redir;
  logic [31:0] inst_in, pc_in;

  logic [2:0]  ready_w, valid_w;
  logic [31:0] inst_w [3];
  logic [31:0] pc_w   [3];
  logic [15:0] st0, fl0, st1, fl1;
  logic [1:0]  st2, fl2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_issue_sched u0 (
    .i_clk(clk), .i_reset(rst), .i_if_valid(ifv), .i_if_inst(inst_in), .i_if_pc(pc_in),
    .o_if_ready(ready_w[0]), .o_id_valid(valid_w[0]), .o_id_inst(inst_w[0]), .o_id_pc(pc_w[0]),
    .i_id_ready(idr), .i_ex_redirect(redir), .o_stall_cnt(st0), .o_flush_cnt(fl0));

  id_issue_sched #(.FLUSH_CYCLES(3)) u1 (
    .i_clk(clk), .i_reset(rst), .i_if_valid(ifv), .i_if_inst(inst_in), .i_if_pc(pc_in),
    .o_if_ready(ready_w[1]), .o_id_valid(valid_w[1]), .o_id_inst(inst_w[1]), .o_id_pc(pc_w[1]),
    .i_id_ready(idr), .i_ex_redirect(redir), .o_stall_cnt(st1), .o_flush_cnt(fl1));

  id_issue_sched #(.CNT_W(2)) u2 (
    .i_clk(clk), .i_reset(rst), .i_if_valid(ifv), .i_if_inst(inst_in), .i_if_pc(pc_in),
    .o_if_ready(ready_w[2]), .o_id_valid(valid_w[2]), .o_id_inst(inst_w[2]), .o_id_pc(pc_w[2]),
    .i_id_ready(idr), .i_ex_redirect(redir), .o_stall_cnt(st2), .o_flush_cnt(fl2));

  // Behavioural model: 'drop' is the number of cycles still to discard fetch beats.
  typedef struct {
    bit          v;
    logic [31:0] inst;
    logic [31:0] pc;
    bit          pend;
    logic [4:0]  rd;
    int          drop;
    int          stalls;
    int          flushes;
  } mdl_t;

  mdl_t m [3];
  int   fc   [3] = '{1, 3, 1};
  int   cmax [3] = '{65535, 65535, 3};
  bit   m_init = 1'b0;

  typedef struct {
    bit          rst, ifv;
    logic [31:0] inst, pc;
    bit          idr, redir, chk;
    bit          e_valid, e_ready;
    logic [31:0] e_inst, e_pc;
    int          e_stall, e_flush;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic bit reads_rs1(input logic [4:0] o);
    return o inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11001};
  endfunction

  function automatic bit reads_rs2(input logic [4:0] o);
    return o inside {5'b01100, 5'b01000, 5'b11000};
  endfunction

  function automatic void m_out(input mdl_t s, input bit rd_i, input bit idr_i,
                                output bit haz, output bit ev, output bit er, output bit iss);
    haz = s.pend && s.v && ((reads_rs1(s.inst[6:2]) && s.inst[19:15] == s.rd) ||
                            (reads_rs2(s.inst[6:2]) && s.inst[24:20] == s.rd));
    ev  = s.v && (s.drop == 0) && !haz && !rd_i;
    iss = ev && idr_i;
    er  = !s.v || iss || (s.drop > 0) || rd_i;
  endfunction

  // Drive one cycle's inputs and compare all instances against the model at the negedge.
  task automatic drive(input bit r, input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ir, input bit rd_i);
    logic [31:0] sa [3];
    logic [31:0] fa [3];
    bit haz, ev, er, iss;
    rst = r; ifv = iv; inst_in = ins; pc_in = pc; idr = ir; redir = rd_i;
    @(negedge clk);
    sa[0] = 32'(st0); sa[1] = 32'(st1); sa[2] = 32'(st2);
    fa[0] = 32'(fl0); fa[1] = 32'(fl1); fa[2] = 32'(fl2);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        chk("rst_id_valid", k, 32'(valid_w[k]), 32'd0);
        chk("rst_if_ready", k, 32'(ready_w[k]), 32'd1);
      end else if (m_init) begin
        m_out(m[k], rd_i, ir, haz, ev, er, iss);
        chk("id_valid",  k, 32'(valid_w[k]), 32'(ev));
        chk("if_ready",  k, 32'(ready_w[k]), 32'(er));
        chk("id_inst",   k, inst_w[k], m[k].inst);
        chk("id_pc",     k, pc_w[k], m[k].pc);
        chk("stall_cnt", k, sa[k], 32'(m[k].stalls));
        chk("flush_cnt", k, fa[k], 32'(m[k].flushes));
      end
    end
  endtask

  task automatic advance();
    mdl_t s;
    bit haz, ev, er, iss, run;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      s = m[k];
      if (rst) begin
        s.v = 0; s.inst = NOP; s.pc = 0; s.pend = 0; s.rd = 0;
        s.drop = 0; s.stalls = 0; s.flushes = 0;
      end else begin
        m_out(s, redir, idr, haz, ev, er, iss);
        if (redir) begin
          s.v = 0; s.pend = 0; s.drop = fc[k] - 1;
          if (s.flushes < cmax[k]) s.flushes++;
        end else begin
          run = (s.drop == 0);
          if (s.drop > 0) s.drop--;
          if (haz && idr) begin
            s.pend = 0;
            if (s.stalls < cmax[k]) s.stalls++;
          end else begin
            if (iss && s.inst[6:2] == 5'b00000 && s.inst[11:7] != 5'd0) begin
              s.pend = 1; s.rd = s.inst[11:7];
            end else if (idr) begin
              s.pend = 0;
            end
            if (ifv && er && run) begin
              s.v = 1; s.inst = inst_in; s.pc = pc_in;
            end else if (iss) begin
              s.v = 0;
            end
          end
        end
      end
      m[k] = s;
    end
    if (rst) m_init = 1'b1;
    #1;
  endtask

  task automatic cyc(input bit r, input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ir, input bit rd_i);
    drive(r, iv, ins, pc, ir, rd_i);
    advance();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  ops [10] = '{5'b00000, 5'b01100, 5'b00100, 5'b01000, 5'b11000,
                              5'b11001, 5'b11011, 5'b01101, 5'b00101, 5'b11100};
    logic [4:0]  opc, r1, r2, rdv;
    logic [6:0]  hi;
    logic [2:0]  f3;
    opc = ops[$urandom_range(0, 9)];
    r1  = 5'($urandom_range(0, 3));
    r2  = 5'($urandom_range(0, 3));
    rdv = 5'($urandom_range(0, 3));
    hi  = 7'($urandom);
    f3  = 3'($urandom);
    return {hi, r2, r1, f3, rdv, opc, 2'b11};
  endfunction

  initial begin
    logic [31:0] fpc [7] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218};
    bit          fre [7] = '{0, 1, 0, 1, 0, 0, 0};
    vec_t v;

    // rst ifv inst pc idr redir chk | valid ready inst pc stall flush
    tbl.push_back('{1, 0, 32'h0, 32'h000, 1, 0, 0, 0, 1, NOP,  32'h000, 0, 0});
    tbl.push_back('{0, 1, LW5,   32'h100, 1, 0, 1, 0, 1, NOP,  32'h000, 0, 0});
    tbl.push_back('{0, 1, ADD6,  32'h104, 1, 0, 1, 1, 1, LW5,  32'h100, 0, 0});
    tbl.push_back('{0, 1, ADD7,  32'h108, 1, 0, 1, 0, 0, ADD6, 32'h104, 0, 0});
    tbl.push_back('{0, 1, ADD7,  32'h108, 1, 0, 1, 1, 1, ADD6, 32'h104, 1, 0});
    tbl.push_back('{0, 1, LW0,   32'h10C, 1, 0, 1, 1, 1, ADD7, 32'h108, 1, 0});
    tbl.push_back('{0, 1, ADD60, 32'h110, 1, 0, 1, 1, 1, LW0,  32'h10C, 1, 0});
    tbl.push_back('{0, 1, LW5,   32'h114, 1, 0, 1, 1, 1, ADD60,32'h110, 1, 0});
    tbl.push_back('{0, 1, LUI5,  32'h118, 1, 0, 1, 1, 1, LW5,  32'h114, 1, 0});
    tbl.push_back('{0, 0, 32'h0, 32'h000, 1, 0, 1, 1, 1, LUI5, 32'h118, 1, 0});
    tbl.push_back('{0, 1, ADD6,  32'h11C, 1, 0, 1, 0, 1, LUI5, 32'h118, 1, 0});
    tbl.push_back('{0, 1, ADD7,  32'h040, 1, 1, 1, 0, 1, ADD6, 32'h11C, 1, 0});
    tbl.push_back('{0, 1, ADD7,  32'h080, 1, 0, 1, 0, 1, ADD6, 32'h11C, 1, 1});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{0, 1, LW5, 32'h084, 0, 0, 1, 1, 0, ADD7, 32'h080, 1, 1});
    tbl.push_back('{0, 1, LW5,   32'h084, 1, 0, 1, 1, 1, ADD7, 32'h080, 1, 1});
    tbl.push_back('{0, 1, ADD6,  32'h088, 1, 0, 1, 1, 1, LW5,  32'h084, 1, 1});
    tbl.push_back('{0, 0, 32'h0, 32'h000, 0, 0, 1, 0, 0, ADD6, 32'h088, 1, 1});
    tbl.push_back('{0, 0, 32'h0, 32'h000, 0, 0, 1, 0, 0, ADD6, 32'h088, 1, 1});
    tbl.push_back('{1, 0, 32'h0, 32'h000, 1, 0, 0, 0, 1, NOP,  32'h000, 0, 0});
    tbl.push_back('{0, 0, 32'h0, 32'h000, 1, 0, 1, 0, 1, NOP,  32'h000, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.rst, v.ifv, v.inst, v.pc, v.idr, v.redir);
      chk("tbl_valid", i, 32'(valid_w[0]), 32'(v.e_valid));
      chk("tbl_ready", i, 32'(ready_w[0]), 32'(v.e_ready));
      if (v.chk) begin
        chk("tbl_inst",  i, inst_w[0], v.e_inst);
        chk("tbl_pc",    i, pc_w[0], v.e_pc);
        chk("tbl_stall", i, 32'(st0), 32'(v.e_stall));
        chk("tbl_flush", i, 32'(fl0), 32'(v.e_flush));
      end
      advance();
    end

    // Three-cycle flush window on u1, restarted by a second redirect.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, ADD7, fpc[i], 1, fre[i]);
      if (i > 0) begin
        chk("fl3_ready", i, 32'(ready_w[1]), 32'd1);
        chk("fl3_valid", i, 32'(valid_w[1]), 32'd0);
      end
      advance();
    end
    drive(0, 0, 32'h0, 32'h0, 1, 0);
    chk("fl3_first_valid", 7, 32'(valid_w[1]), 32'd1);
    chk("fl3_first_pc",    7, pc_w[1], 32'h218);
    chk("fl3_flush_cnt",   7, 32'(fl1), 32'd2);
    advance();

    // Counter saturation: 5 redirects on a 2-bit counter.
    cyc(1, 0, 32'h0, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, ADD7, 32'h300, 1, 1);
    drive(0, 0, 32'h0, 32'h0, 1, 0);
    chk("sat_flush_w2",  0, 32'(fl2), 32'd3);
    chk("sat_flush_w16", 0, 32'(fl0), 32'd5);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), rand_inst(),
          ($urandom & 32'hFFFF_FFFC), ($urandom_range(0, 3) != 0), ($urandom_range(0, 12) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_issue_sched.md
# id_issue_sched

Decode-stage scheduler owning the IF/ID pipeline register of the pipelined RV32I core. It accepts instructions from fetch, presents them to the decode stage (immediate generator, register file read, control decode), inserts one bubble on a load-use hazard, and squashes wrong-path instructions when EX redirects the PC. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `FLUSH_CYCLES`, default 1: cycles, counting the redirect cycle itself, during which incoming fetch beats are accepted and discarded. Range 1-7.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `i_clk`  in  1  core clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_if_valid`  in  1  fetch beat valid.
- `i_if_inst`  in  32  fetched instruction.
- `i_if_pc`  in  32  PC of the fetched instruction.
- `o_if_ready`  out  1  scheduler accepts the fetch beat this cycle.
- `o_id_valid`  out  1  instruction presented to decode/EX is real (0 = bubble).
- `o_id_inst`  out  32  IF/ID instruction; drives the immediate generator and decoder.
- `o_id_pc`  out  32  IF/ID PC.
- `i_id_ready`  in  1  EX accepts the ID slot (bubble or instruction) this cycle.
- `i_ex_redirect`  in  1  taken branch or jump resolved in EX this cycle.
- `o_stall_cnt`  out  CNT_W  load-use bubbles inserted, saturating.
- `o_flush_cnt`  out  CNT_W  redirects seen, saturating.

## Operation
- IF/ID register holds `ir_valid`, `ir_inst` and `ir_pc`. A beat is captured when `i_if_valid && o_if_ready`, state is RUN, and `i_ex_redirect` is 0.
- Hazard:
  - `ld_pend` is set when a load (opcode[6:2] = 00000) with rd ≠ 0 is issued. `ld_rd` holds that rd.
  - `ld_pend` clears on any cycle with `i_id_ready` = 1 that does not issue a new load.
  - `hazard = ld_pend && ir_valid && ((uses_rs1 && rs1 == ld_rd) || (uses_rs2 && rs2 == ld_rd))`.
- Source use by opcode[6:2]:
  - rs1 is used by 01100, 00100, 00000, 01000, 11000 and 11001.
  - rs2 is used by 01100, 01000 and 11000.
  - LUI, AUIPC and JAL use no source register.
- `o_id_valid = ir_valid && state == RUN && !hazard && !i_ex_redirect`.
- Issue = `o_id_valid && i_id_ready`.
- A cycle with `hazard && i_id_ready` inserts a bubble:
  - the IF/ID register holds its contents;
  - `ld_pend` clears;
  - `o_stall_cnt` increments.
- `o_if_ready = !ir_valid || issue || state == FLUSH || i_ex_redirect`. Accepted beats are dropped in FLUSH and on a redirect cycle.
- FSM with two states, RUN and FLUSH, and a 3-bit `fl_cnt`:
  - Any state with `i_ex_redirect`: clear `ir_valid` and `ld_pend`, increment `o_flush_cnt`. If FLUSH_CYCLES > 1, go to FLUSH with `fl_cnt` = FLUSH_CYCLES-1; otherwise stay in RUN.
  - FLUSH: decrement `fl_cnt` each cycle and return to RUN when it reaches 1. A redirect while in FLUSH reloads `fl_cnt`.
- Priority, highest first: reset, redirect, hazard, normal issue/capture.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - `ir_valid` = 0, `ir_inst` = 32'h0000_0013 (NOP), `ir_pc` = 0;
  - `ld_pend` = 0, state = RUN;
  - both counters = 0.
- Outputs in the reset cycle and the first cycle after it: `o_id_valid` = 0, `o_if_ready` = 1.
- Capture to presentation: 1 cycle. `o_id_inst` and `o_id_pc` come straight from registers.
- Back-to-back issue at 1 instruction/cycle when there is no hazard and `i_id_ready` = 1.
- Load-use costs exactly 1 bubble cycle. If `i_id_ready` = 0 during the hazard, the hazard persists until EX accepts the bubble.
- `o_id_valid` depends combinationally on `i_ex_redirect`; the instruction in IF/ID is never issued in the redirect cycle.
- Reset mid-operation discards the IF/ID contents, pending hazard and FSM state in the same edge. Counters clear.

## Structure
- Put these in shared `riscv_pkg`:
  - opcode constants: `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JALR`, `OP_JAL`, `OP_OPIMM`, `OP_OP`, `OP_LUI`, `OP_AUIPC` (5-bit, inst[6:2]);
  - `NOP_INST`;
  - enum `id_sched_state_e` {RUN, FLUSH}.
- One combinational sub-module, `id_src_use`: takes inst[31:0] and returns `uses_rs1`, `uses_rs2`, `rs1`, `rs2`, `is_load` and `rd`. The same decode is reusable by the forwarding unit.

## Test plan
- Hazard with bubble: issue `lw x5,0(x1)` then `add x6,x5,x2`, `i_id_ready` = 1. Expect `o_id_valid` to read 1, 0, 1 over three cycles, `o_id_inst` to hold the add through the bubble, and `o_stall_cnt` = 1.
- No false hazard:
  - `lw x0,0(x1)` followed by `add x6,x0,x2` issues back-to-back with no bubble;
  - `lw x5` followed by `lui x5,1` also issues with no bubble.
- Redirect: with `add` in IF/ID, pulse `i_ex_redirect` while fetch presents `pc` = 0x40. Expect `o_id_valid` = 0 that cycle, both beats discarded, the next beat at `pc` = 0x80 presented one cycle later, and `o_flush_cnt` = 1.
- FLUSH_CYCLES = 3: after a redirect, the next 2 fetch beats are accepted (`o_if_ready` = 1) and dropped. A second redirect during FLUSH restarts the 3-cycle window.
- Backpressure: hold `i_id_ready` = 0 for 4 cycles with a full IF/ID register. Expect `o_if_ready` = 0 and `o_id_inst` stable. On release, issue resumes at 1 instruction/cycle.
- Reset mid-hazard and counter saturation:
  - assert `i_reset` during a load-use stall: next cycle `o_id_valid` = 0 and counters = 0;
  - with CNT_W = 2 and 5 redirects: `o_flush_cnt` = 3.
